mem_arbiter: RTL and testbench

- Shares the single unified memory between instruction fetch (IF) and load/store (D) requesters.
- The memory has a separate read port and write port, and reads on the clock's falling edge.
- Per cycle the block issues at most one read, plus one D write when a D write does not conflict with a concurrent IF read.
- Returns read data to the owning requester with a valid pulse. Bounds IF starvation under continuous D traffic.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/rd_tag_pipe.sv | 42 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_MAX_STARVE = 4;

  // Which requester a read belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Which requester wins a read-port conflict.
  typedef enum logic {
    D_PRI = 1'b0,
    F_PRI = 1'b1
  } pri_e;

  // One in-flight read as it travels toward the data return point.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Build the tag for a read issued on behalf of 'owner' (OWN_NONE = no read).
  function automatic rd_tag_t read_tag(input owner_e owner);
    rd_tag_t t;
    t.valid = (owner != OWN_NONE);
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays the issue tag of each read so it lines up with the cycle in which
// the memory's read data can be captured. Stage 0 is the issue tag itself
// (data is capturable at the edge closing the issue cycle), so DEPTH stages
// need DEPTH-1 registers.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LATENCY
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  generate
    if (DEPTH <= 1) begin : g_direct
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign tag_o = tag_i;
    end else begin : g_shift
      rd_tag_t stage_q [DEPTH-1];

      // Shift tags one stage per cycle; reset drops everything in flight.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= tag_i;
          for (int i = 1; i < DEPTH - 1; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign tag_o = stage_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory (separate read and write ports) between the
// instruction-fetch and load/store requesters, with bounded IF starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen
);

  localparam int              CNT_W   = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARVE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pri_e              pri_q, pri_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_gnt_s, d_gnt_s;
  rd_tag_t           issue_tag_s, exit_tag_s;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // Decide grants: a D write shares the cycle with an IF read unless both
  // hit the same address, in which case IF waits so it reads the new data.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (rst) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (d_req && d_we) begin
      d_gnt_s  = 1'b1;
      if_gnt_s = if_req && (if_addr != d_addr);
    end else if (d_req && if_req) begin
      if (pri_q == F_PRI) begin
        if_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else begin
      if_gnt_s = if_req;
      d_gnt_s  = d_req;
    end
  end

  // Drive the memory ports from the grants; idle ports read as zero.
  always_comb begin
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    mem_wen     = 1'b0;
    issue_tag_s = read_tag(OWN_NONE);
    if (if_gnt_s) begin
      mem_raddr   = if_addr;
      issue_tag_s = read_tag(OWN_IF);
    end else if (d_gnt_s && !d_we) begin
      mem_raddr   = d_addr;
      issue_tag_s = read_tag(OWN_D);
    end else begin
      mem_raddr   = '0;
      issue_tag_s = read_tag(OWN_NONE);
    end
    if (d_gnt_s && d_we) begin
      mem_wen   = 1'b1;
      mem_waddr = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_wen = 1'b0;
    end
  end

  // Next starvation count and next priority state. Switching to F_PRI on
  // the count about to reach MAX_STARVE lets IF win in the very next cycle.
  always_comb begin
    cnt_d = cnt_q;
    pri_d = pri_q;
    if (if_req && !if_gnt_s) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = '0;
    end
    case (pri_q)
      D_PRI:   pri_d = (cnt_d == CNT_MAX) ? F_PRI : D_PRI;
      F_PRI:   pri_d = if_gnt_s ? D_PRI : F_PRI;
      default: pri_d = D_PRI;
    endcase
  end

  // Priority state machine and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= D_PRI;
      cnt_q <= '0;
    end else begin
      pri_q <= pri_d;
      cnt_q <= cnt_d;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .tag_i (issue_tag_s),
    .tag_o (exit_tag_s)
  );

  // Capture returning read data for the owner of the exiting tag; rdata
  // holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= exit_tag_s.valid && (exit_tag_s.owner == OWN_IF);
      d_rvalid_q  <= exit_tag_s.valid && (exit_tag_s.owner == OWN_D);
      if (exit_tag_s.valid && (exit_tag_s.owner == OWN_IF)) begin
        if_rdata_q <= mem_rdata;
      end else begin
        if_rdata_q <= if_rdata_q;
      end
      if (exit_tag_s.valid && (exit_tag_s.owner == OWN_D)) begin
        d_rdata_q <= mem_rdata;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

  assign if_gnt    = if_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks with inline cycle
// checks, plus a scoreboard of expected read returns against a monitor.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wen;
  logic [31:0] if_rdata, d_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:255];

  logic [33:0] exp_q [$];
  logic [33:0] obs_q [$];

  int n_tests;
  int n_fail;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .MAX_STARVE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: writes (and bench preloads) on rising edge, reads on falling edge.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_wen === 1'b1) mem[mem_waddr[7:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    mem_rdata <= mem[mem_raddr[7:0]];
  end

  // Monitor: record every read response as {owner, data}; 1 = IF, 2 = D.
  always @(negedge clk) begin
    if (if_rvalid === 1'b1) obs_q.push_back({2'd1, if_rdata});
    if (d_rvalid === 1'b1)  obs_q.push_back({2'd2, d_rdata});
  end

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h99);
    @(negedge clk);
    n_tests++; if ({if_gnt, d_gnt, mem_wen} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_wen: got %b want 000", {if_gnt, d_gnt, mem_wen}); end
    n_tests++; if (mem_raddr !== 32'h0) begin n_fail++; $display("FAIL reset_raddr: got %h want 0", mem_raddr); end
    n_tests++; if ({mem_waddr, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_waddr_wdata: got %h want 0", {mem_waddr, mem_wdata}); end
    n_tests++; if ({if_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, d_rvalid}); end
    n_tests++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_if_only();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back({2'd1, 32'hDEADBEEF});
    @(negedge clk);
    n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL if_only_gnt: got %b want 1", if_gnt); end
    n_tests++; if (mem_raddr !== 32'h10) begin n_fail++; $display("FAIL if_only_raddr: got %h want 10", mem_raddr); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_only_rdata: got %b/%h want 1/deadbeef", if_rvalid, if_rdata); end
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_only_d_rvalid: got %b want 0", d_rvalid); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_only_hold: got %b/%h want 0/deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_read_conflict();
    drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
    exp_q.push_back({2'd2, 32'h22});
    @(negedge clk);
    n_tests++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL rdconf_gnt_n: got %b want 01", {if_gnt, d_gnt}); end
    n_tests++; if (mem_raddr !== 32'h40) begin n_fail++; $display("FAIL rdconf_raddr_n: got %h want 40", mem_raddr); end
    drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back({2'd1, 32'h11});
    @(negedge clk);
    n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rdconf_if_gnt_n1: got %b want 1", if_gnt); end
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h22) begin n_fail++; $display("FAIL rdconf_d_rdata: got %b/%h want 1/22", d_rvalid, d_rdata); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11) begin n_fail++; $display("FAIL rdconf_if_rdata: got %b/%h want 1/11", if_rvalid, if_rdata); end
  endtask

  task automatic test_write_parallel();
    drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h80, 32'h1234);
    exp_q.push_back({2'd1, 32'h11});
    @(negedge clk);
    n_tests++; if ({if_gnt, d_gnt, mem_wen} !== 3'b111) begin n_fail++; $display("FAIL wpar_gnt_wen: got %b want 111", {if_gnt, d_gnt, mem_wen}); end
    n_tests++; if ({mem_raddr, mem_waddr, mem_wdata} !== {32'h20, 32'h80, 32'h1234}) begin n_fail++; $display("FAIL wpar_ports: got %h want 20/80/1234", {mem_raddr, mem_waddr, mem_wdata}); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11) begin n_fail++; $display("FAIL wpar_if_rdata: got %b/%h want 1/11", if_rvalid, if_rdata); end
    n_tests++; if (mem[8'h80] !== 32'h1234) begin n_fail++; $display("FAIL wpar_mem: got %h want 1234", mem[8'h80]); end
    n_tests++; if ({d_rvalid, mem_wen} !== 2'b00) begin n_fail++; $display("FAIL wpar_idle: got %b want 00", {d_rvalid, mem_wen}); end
  endtask

  task automatic test_write_same_addr();
    drive(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 32'h5555);
    @(negedge clk);
    n_tests++; if ({if_gnt, d_gnt, mem_wen} !== 3'b011) begin n_fail++; $display("FAIL wsame_gnt_n: got %b want 011", {if_gnt, d_gnt, mem_wen}); end
    drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back({2'd1, 32'h5555});
    @(negedge clk);
    n_tests++; if (if_gnt !== 1'b1 || mem_raddr !== 32'h80) begin n_fail++; $display("FAIL wsame_gnt_n1: got %b/%h want 1/80", if_gnt, mem_raddr); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h5555) begin n_fail++; $display("FAIL wsame_rdata: got %b/%h want 1/5555", if_rvalid, if_rdata); end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h50, 32'h0);
      if (c == 4) exp_q.push_back({2'd1, 32'hA5A50030});
      else        exp_q.push_back({2'd2, 32'h5A5A0050});
      @(negedge clk);
      n_tests++;
      if ({if_gnt, d_gnt} !== ((c == 4) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL starve_cycle%0d: got %b want %b", c, {if_gnt, d_gnt}, (c == 4) ? 2'b10 : 2'b01);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A5A0050) begin n_fail++; $display("FAIL starve_last_rdata: got %b/%h want 1/5a5a0050", d_rvalid, d_rdata); end
  endtask

  task automatic test_reset_inflight();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
      exp_q.push_back({2'd2, 32'h22});
      @(negedge clk);
      n_tests++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL rstfl_pre%0d: got %b want 01", c, {if_gnt, d_gnt}); end
    end
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    n_tests++; if ({if_gnt, d_gnt, mem_wen} !== 3'b000) begin n_fail++; $display("FAIL rstfl_gnt: got %b want 000", {if_gnt, d_gnt, mem_wen}); end
    n_tests++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'h0) begin n_fail++; $display("FAIL rstfl_ports: got %h want 0", {mem_raddr, mem_waddr, mem_wdata}); end
    drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
    exp_q.push_back({2'd2, 32'h22});
    @(negedge clk);
    n_tests++; if ({if_rvalid, d_rvalid} !== 2'b00 || {if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rstfl_cleared: got %b/%h want 00/0", {if_rvalid, d_rvalid}, {if_rdata, d_rdata}); end
    n_tests++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL rstfl_dpri: got %b want 01", {if_gnt, d_gnt}); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h22) begin n_fail++; $display("FAIL rstfl_after: got %b/%h want 1/22", d_rvalid, d_rdata); end
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_scoreboard();
    logic [33:0] e, o;
    @(negedge clk);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sb_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_resp: got owner %0d data %h want owner %0d data %h", o[33:32], o[31:0], e[33:32], e[31:0]); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;
    test_reset();
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h20, 32'h11);
    preload(8'h40, 32'h22);
    preload(8'h30, 32'hA5A50030);
    preload(8'h50, 32'h5A5A0050);
    test_if_only();
    test_read_conflict();
    test_write_parallel();
    test_write_same_addr();
    test_starvation();
    test_reset_inflight();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
